// File: rtl/etherneco_tx_arbiter.sv
// EtherNeco TX arbiter: shares one PHY TX stream between the ring forward
// path (s0) and the local originate path (s1). A grant lasts a whole frame,
// is followed by an optional inter-frame gap, and beats that arrive in IDLE
// without a frame start are swallowed and counted.
module etherneco_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int IFG_CYCLES     = 12,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  aresetn,
  input  logic                  aclk,
  input  logic                  s0_tfirst,
  input  logic                  s0_tlast,
  input  logic                  s0_tvalid,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  output logic                  s0_tready,
  input  logic                  s1_tfirst,
  input  logic                  s1_tlast,
  input  logic                  s1_tvalid,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  output logic                  s1_tready,
  output logic                  m_tfirst,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  input  logic                  m_tready,
  output logic                  busy,
  output logic [1:0]            grant,
  output logic [15:0]           drop_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam bit         HAS_GAP    = (IFG_CYCLES > 0);
  localparam bit         FIXED_PRIO = (FIXED_PRIORITY != 0);
  localparam logic [7:0] IFG_LOAD   = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

  // Saturating add used by the stray-beat counter.
  function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, base} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  gap_cnt_r;
  logic [7:0]  gap_cnt_nxt_s;
  logic        last_grant_r;      // 0: s0 was granted last, 1: s1 was granted last
  logic        last_grant_nxt_s;
  logic [15:0] drop_count_r;
  logic [1:0]  drop_inc_s;
  logic        armed_r;           // low for the first cycle after reset release

  logic        req0_s;
  logic        req1_s;
  logic        stray0_s;
  logic        stray1_s;

  // Arbitration only looks at inputs once the reset-release cycle has passed,
  // so a reset-held armed_r also keeps every ready low while aresetn is low.
  assign req0_s   = armed_r & s0_tvalid &  s0_tfirst;
  assign req1_s   = armed_r & s1_tvalid &  s1_tfirst;
  assign stray0_s = armed_r & s0_tvalid & ~s0_tfirst;
  assign stray1_s = armed_r & s1_tvalid & ~s1_tfirst;

  // Holds off grant decisions for one cycle after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= 1'b1;
    end
  end

  // Next-state, gap counter, round-robin memory and stray increment.
  always_comb begin
    state_nxt_s      = state_r;
    gap_cnt_nxt_s    = gap_cnt_r;
    last_grant_nxt_s = last_grant_r;
    drop_inc_s       = 2'd0;
    case (state_r)
      IDLE: begin
        drop_inc_s = {1'b0, stray0_s} + {1'b0, stray1_s};
        if (req0_s && req1_s) begin
          if (FIXED_PRIO || last_grant_r) begin
            state_nxt_s      = GRANT0;
            last_grant_nxt_s = 1'b0;
          end else begin
            state_nxt_s      = GRANT1;
            last_grant_nxt_s = 1'b1;
          end
        end else if (req0_s) begin
          state_nxt_s      = GRANT0;
          last_grant_nxt_s = 1'b0;
        end else if (req1_s) begin
          state_nxt_s      = GRANT1;
          last_grant_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT0: begin
        if (s0_tvalid && m_tready && s0_tlast) begin
          if (HAS_GAP) begin
            state_nxt_s   = GAP;
            gap_cnt_nxt_s = IFG_LOAD;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = GRANT0;
        end
      end
      GRANT1: begin
        if (s1_tvalid && m_tready && s1_tlast) begin
          if (HAS_GAP) begin
            state_nxt_s   = GAP;
            gap_cnt_nxt_s = IFG_LOAD;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = GRANT1;
        end
      end
      GAP: begin
        if (gap_cnt_r == 8'd0) begin
          state_nxt_s = IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        gap_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // State, gap counter, last grant and drop counter registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= IDLE;
      gap_cnt_r    <= 8'd0;
      last_grant_r <= 1'b1;
      drop_count_r <= 16'd0;
    end else begin
      state_r      <= state_nxt_s;
      gap_cnt_r    <= gap_cnt_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      drop_count_r <= sat_add16(drop_count_r, drop_inc_s);
    end
  end

  // Zero-latency stream mux, ready steering and status decode.
  always_comb begin
    m_tfirst  = 1'b0;
    m_tlast   = 1'b0;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    busy      = 1'b0;
    grant     = 2'b00;
    case (state_r)
      IDLE: begin
        s0_tready = stray0_s;
        s1_tready = stray1_s;
      end
      GRANT0: begin
        m_tfirst  = s0_tfirst;
        m_tlast   = s0_tlast;
        m_tvalid  = s0_tvalid;
        m_tdata   = s0_tdata;
        s0_tready = m_tready;
        busy      = 1'b1;
        grant     = 2'b01;
      end
      GRANT1: begin
        m_tfirst  = s1_tfirst;
        m_tlast   = s1_tlast;
        m_tvalid  = s1_tvalid;
        m_tdata   = s1_tdata;
        s1_tready = m_tready;
        busy      = 1'b1;
        grant     = 2'b10;
      end
      GAP: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_etherneco_tx_arbiter.sv
// Self-checking bench for etherneco_tx_arbiter. dut0 uses the default
// parameters (round-robin, 12-cycle gap) with a scoreboard monitor on its
// output; dut1 is fixed-priority with no gap.
module tb_etherneco_tx_arbiter;

  logic        aclk;
  logic        aresetn;
  logic        s0_tfirst, s0_tlast, s0_tvalid, s0_tready;
  logic [7:0]  s0_tdata;
  logic        s1_tfirst, s1_tlast, s1_tvalid, s1_tready;
  logic [7:0]  s1_tdata;
  logic        m_tfirst, m_tlast, m_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tready = 1'b1;
  logic        busy;
  logic [1:0]  grant;
  logic [15:0] drop_count;

  logic        f_s0_tfirst, f_s0_tlast, f_s0_tvalid, f_s0_tready;
  logic [7:0]  f_s0_tdata;
  logic        f_s1_tfirst, f_s1_tlast, f_s1_tvalid, f_s1_tready;
  logic [7:0]  f_s1_tdata;
  logic        f_m_tfirst, f_m_tlast, f_m_tvalid;
  logic [7:0]  f_m_tdata;
  logic        f_m_tready;
  logic        f_busy;
  logic [1:0]  f_grant;
  logic [15:0] f_drop_count;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  q0[$];
  logic [9:0]  q1[$];
  int          order_q[$];
  bit          in_frame = 1'b0;
  bit          bp_en = 1'b0;
  logic [9:0]  got_b;
  logic [9:0]  exp_b;

  etherneco_tx_arbiter #(.DATA_WIDTH(8), .IFG_CYCLES(12), .FIXED_PRIORITY(0)) dut0 (
    .aresetn(aresetn), .aclk(aclk),
    .s0_tfirst(s0_tfirst), .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid),
    .s0_tdata(s0_tdata), .s0_tready(s0_tready),
    .s1_tfirst(s1_tfirst), .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid),
    .s1_tdata(s1_tdata), .s1_tready(s1_tready),
    .m_tfirst(m_tfirst), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tdata(m_tdata), .m_tready(m_tready),
    .busy(busy), .grant(grant), .drop_count(drop_count)
  );

  etherneco_tx_arbiter #(.DATA_WIDTH(8), .IFG_CYCLES(0), .FIXED_PRIORITY(1)) dut1 (
    .aresetn(aresetn), .aclk(aclk),
    .s0_tfirst(f_s0_tfirst), .s0_tlast(f_s0_tlast), .s0_tvalid(f_s0_tvalid),
    .s0_tdata(f_s0_tdata), .s0_tready(f_s0_tready),
    .s1_tfirst(f_s1_tfirst), .s1_tlast(f_s1_tlast), .s1_tvalid(f_s1_tvalid),
    .s1_tdata(f_s1_tdata), .s1_tready(f_s1_tready),
    .m_tfirst(f_m_tfirst), .m_tlast(f_m_tlast), .m_tvalid(f_m_tvalid),
    .m_tdata(f_m_tdata), .m_tready(f_m_tready),
    .busy(f_busy), .grant(f_grant), .drop_count(f_drop_count)
  );

  // Clock.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // PHY ready: constant 1, or a 50% random pattern while backpressure is on.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor for dut0: every output handshake pops the owner's queue.
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        in_frame = 1'b0;
      end else if (m_tvalid && m_tready) begin
        got_b = {m_tfirst, m_tlast, m_tdata};
        checks++;
        if (grant === 2'b01 && q0.size() > 0) begin
          exp_b = q0.pop_front();
          if (got_b !== exp_b) begin
            errors++;
            $display("FAIL sb_s0_beat: got %h required %h", got_b, exp_b);
          end
        end else if (grant === 2'b10 && q1.size() > 0) begin
          exp_b = q1.pop_front();
          if (got_b !== exp_b) begin
            errors++;
            $display("FAIL sb_s1_beat: got %h required %h", got_b, exp_b);
          end
        end else begin
          errors++;
          $display("FAIL sb_unexpected: beat %h with grant %b, required no output beat", got_b, grant);
        end
        checks++;
        if (m_tfirst !== !in_frame) begin
          errors++;
          $display("FAIL framing: tfirst %b while in_frame %b, required tfirst = !in_frame", m_tfirst, in_frame);
        end
        if (m_tfirst) order_q.push_back((grant === 2'b10) ? 1 : 0);
        in_frame = !m_tlast;
      end
    end
  end

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 3000000");
    $fatal(1, "watchdog expired");
  end

  task automatic set_port(input int p, input logic v, input logic f, input logic l, input logic [7:0] d);
    if (p == 0) begin
      s0_tvalid = v; s0_tfirst = f; s0_tlast = l; s0_tdata = d;
    end else begin
      s1_tvalid = v; s1_tfirst = f; s1_tlast = l; s1_tdata = d;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    wait_cycles(2);
    aresetn = 1'b1;
    wait_cycles(2);
  endtask

  // Drives beats start..start+cnt-1 of a frame of length total; fwd pushes them to the scoreboard.
  task automatic send_beats(input int p, input int start, input int cnt, input int total,
                            input logic [7:0] base, input bit gaps, input bit fwd);
    int t;
    logic [7:0] d;
    logic f, l;
    for (int i = start; i < start + cnt; i++) begin
      if (gaps && i > start && $urandom_range(0, 3) == 0) begin
        set_port(p, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge aclk);
        #1;
      end
      d = base + 8'(i);
      f = (i == 0);
      l = (i == total - 1);
      set_port(p, 1'b1, f, l, d);
      if (fwd) begin
        if (p == 0) q0.push_back({f, l, d});
        else        q1.push_back({f, l, d});
      end
      t = 0;
      forever begin
        @(negedge aclk);
        if ((p == 0) ? s0_tready : s1_tready) break;
        t++;
        if (t >= 2000) begin
          checks++;
          errors++;
          $display("FAIL hs_timeout: port %0d beat %0d waited %0d cycles, required acceptance", p, i, t);
          break;
        end
      end
      @(posedge aclk);
      #1;
    end
    set_port(p, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 3000) begin
      @(posedge aclk);
      t++;
    end
    @(posedge aclk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d beats outstanding, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 8'h33);
    set_port(1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    checks++;
    if ({m_tvalid, m_tfirst, m_tlast, s0_tready, s1_tready, busy, grant} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {m_tvalid, m_tfirst, m_tlast, s0_tready, s1_tready, busy, grant});
    end
    checks++;
    if (m_tdata !== 8'h00 || drop_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: m_tdata %h drop_count %h, required 00 0000", m_tdata, drop_count);
    end
    wait_cycles(3);
    // One-beat frame pending on s1 across reset release.
    set_port(0, 1'b0, 1'b0, 1'b0, 8'h00);
    set_port(1, 1'b1, 1'b1, 1'b1, 8'hA5);
    q1.push_back({1'b1, 1'b1, 8'hA5});
    aresetn = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    checks++;
    if (grant !== 2'b00 || s1_tready !== 1'b0) begin
      errors++;
      $display("FAIL release_holdoff: grant %b s1_tready %b after first edge, required 00 0", grant, s1_tready);
    end
    @(negedge aclk);
    checks++;
    if (grant !== 2'b10 || m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL release_grant: grant %b m_tvalid %b after second edge, required 10 1", grant, m_tvalid);
    end
    @(posedge aclk);
    #1;
    set_port(1, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_drain();
    wait_cycles(20);
  endtask

  task automatic test_single();
    fork
      send_beats(1, 0, 64, 64, 8'h10, 1'b0, 1'b1);
      begin
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b0 || grant !== 2'b00) begin
          errors++;
          $display("FAIL single_req_cycle: m_tvalid %b grant %b, required 0 00", m_tvalid, grant);
        end
        @(negedge aclk);
        checks++;
        if (grant !== 2'b10 || m_tvalid !== 1'b1 || m_tfirst !== 1'b1 || m_tdata !== 8'h10 || s1_tready !== m_tready) begin
          errors++;
          $display("FAIL single_latency: grant %b valid %b first %b data %h, required 10 1 1 10",
                   grant, m_tvalid, m_tfirst, m_tdata);
        end
      end
    join
    fork
      send_beats(0, 0, 4, 4, 8'h80, 1'b0, 1'b1);
      begin
        int n_idle;
        int n_busy;
        n_idle = 0;
        n_busy = 0;
        forever begin
          @(negedge aclk);
          if (grant !== 2'b00 || n_idle >= 100) break;
          n_idle++;
          if (busy) n_busy++;
        end
        checks++;
        if (n_idle != 13) begin
          errors++;
          $display("FAIL ifg_length: %0d ungranted cycles after tlast, required 13", n_idle);
        end
        checks++;
        if (n_busy != 12) begin
          errors++;
          $display("FAIL gap_busy: %0d gap cycles, required 12", n_busy);
        end
        checks++;
        if (grant !== 2'b01) begin
          errors++;
          $display("FAIL ifg_next_grant: grant %b, required 01", grant);
        end
      end
    join
    wait_drain();
    wait_cycles(20);
  endtask

  task automatic test_backpressure();
    bp_en = 1'b1;
    fork
      send_beats(0, 0, 30, 30, 8'h40, 1'b1, 1'b1);
      begin
        int t;
        bit prev_hs;
        t = 0;
        prev_hs = 1'b0;
        while (grant !== 2'b01 && t < 200) begin
          @(negedge aclk);
          t++;
        end
        forever begin
          @(negedge aclk);
          t++;
          if (grant !== 2'b01 || t > 4000) break;
          prev_hs = m_tvalid & m_tready & m_tlast;
        end
        checks++;
        if (prev_hs !== 1'b1) begin
          errors++;
          $display("FAIL bp_release: grant dropped to %b without tlast handshake, required release on tlast", grant);
        end
      end
    join
    bp_en = 1'b0;
    wait_drain();
    wait_cycles(20);
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 1, 0, 1, 0, 1};
    do_reset();
    order_q.delete();
    fork
      for (int k = 0; k < 3; k++) send_beats(0, 0, 5, 5, 8'(8'h20 + 8'(k * 16)), 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) send_beats(1, 0, 7, 7, 8'(8'hA0 + 8'(k * 16)), 1'b0, 1'b1);
    join
    wait_drain();
    checks++;
    if (order_q.size() != 6) begin
      errors++;
      $display("FAIL rr_count: %0d frames, required 6", order_q.size());
    end
    for (int k = 0; k < 6; k++) begin
      if (k < order_q.size()) begin
        checks++;
        if (order_q[k] != exp_order[k]) begin
          errors++;
          $display("FAIL rr_order: frame %0d from s%0d, required s%0d", k, order_q[k], exp_order[k]);
        end
      end
    end
    wait_cycles(20);
  endtask

  task automatic test_stray();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_port(1, 1'b1, 1'b0, 1'b0, 8'(i));
      @(negedge aclk);
      checks++;
      if (s1_tready !== 1'b1 || m_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL stray_accept: beat %0d tready %b m_tvalid %b, required 1 0", i, s1_tready, m_tvalid);
      end
      @(posedge aclk);
      #1;
    end
    set_port(1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge aclk);
    checks++;
    if (drop_count !== 16'd5) begin
      errors++;
      $display("FAIL stray_count: drop_count %0d, required 5", drop_count);
    end
    @(posedge aclk);
    #1;
    // Both ports stray together: +2 per cycle, 5 + 2*32765 = 65535.
    set_port(0, 1'b1, 1'b0, 1'b0, 8'h11);
    set_port(1, 1'b1, 1'b0, 1'b0, 8'h22);
    wait_cycles(32765);
    set_port(0, 1'b0, 1'b0, 1'b0, 8'h00);
    set_port(1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge aclk);
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL stray_dual: drop_count %h, required FFFF", drop_count);
    end
    @(posedge aclk);
    #1;
    set_port(1, 1'b1, 1'b0, 1'b0, 8'h01);
    wait_cycles(1);
    set_port(0, 1'b1, 1'b0, 1'b0, 8'h02);
    wait_cycles(1);
    set_port(0, 1'b0, 1'b0, 1'b0, 8'h00);
    set_port(1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge aclk);
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL stray_saturate: drop_count %h, required FFFF", drop_count);
    end
    wait_cycles(2);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_beats(0, 0, 20, 60, 8'h00, 1'b0, 1'b1);
    set_port(0, 1'b1, 1'b0, 1'b0, 8'h14);
    aresetn = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, m_tfirst, m_tlast, s0_tready, s1_tready, busy, grant} !== 8'b0 || m_tdata !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: ctrl %b data %h, required 00000000 00",
               {m_tvalid, m_tfirst, m_tlast, s0_tready, s1_tready, busy, grant}, m_tdata);
    end
    wait_cycles(2);
    aresetn = 1'b1;
    send_beats(0, 20, 40, 60, 8'h00, 1'b0, 1'b0);
    @(negedge aclk);
    checks++;
    if (drop_count !== 16'd40) begin
      errors++;
      $display("FAIL midreset_drops: drop_count %0d, required 40", drop_count);
    end
    @(posedge aclk);
    #1;
    send_beats(0, 0, 8, 8, 8'hC0, 1'b0, 1'b1);
    wait_drain();
    wait_cycles(20);
  endtask

  task automatic test_fixed_priority();
    int idx;
    int beats;
    int viol;
    do_reset();
    idx = 0;
    beats = 0;
    viol = 0;
    f_s1_tvalid = 1'b1; f_s1_tfirst = 1'b1; f_s1_tlast = 1'b0; f_s1_tdata = 8'h77;
    for (int c = 0; c < 60; c++) begin
      f_s0_tvalid = 1'b1;
      f_s0_tfirst = (idx == 0);
      f_s0_tlast  = (idx == 3);
      f_s0_tdata  = 8'(idx);
      @(negedge aclk);
      if (f_grant === 2'b10 || f_s1_tready !== 1'b0) viol++;
      if (f_busy !== (f_grant !== 2'b00)) viol++;
      if (f_grant === 2'b01 && {f_m_tvalid, f_m_tfirst, f_m_tlast, f_m_tdata} !==
          {f_s0_tvalid, f_s0_tfirst, f_s0_tlast, f_s0_tdata}) viol++;
      if (f_s0_tready) begin
        beats++;
        idx = (idx + 1) % 4;
      end
      @(posedge aclk);
      #1;
    end
    f_s0_tvalid = 1'b0;
    f_s1_tvalid = 1'b0;
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL fixed_s1_blocked: %0d cycles with s1 granted/ready or bad mux, required 0", viol);
    end
    checks++;
    if (beats != 48) begin
      errors++;
      $display("FAIL fixed_throughput: %0d s0 beats in 60 cycles, required 48", beats);
    end
    checks++;
    if (f_drop_count !== 16'd0) begin
      errors++;
      $display("FAIL fixed_drops: drop_count %0d, required 0", f_drop_count);
    end
  endtask

  // Test sequence.
  initial begin
    aresetn = 1'b0;
    set_port(0, 1'b0, 1'b0, 1'b0, 8'h00);
    set_port(1, 1'b0, 1'b0, 1'b0, 8'h00);
    f_s0_tvalid = 1'b0; f_s0_tfirst = 1'b0; f_s0_tlast = 1'b0; f_s0_tdata = 8'h00;
    f_s1_tvalid = 1'b0; f_s1_tfirst = 1'b0; f_s1_tlast = 1'b0; f_s1_tdata = 8'h00;
    f_m_tready = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_stray();
    test_reset_mid_frame();
    test_fixed_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/etherneco_tx_arbiter.md
ETHERNECO_TX_ARBITER -- requirements
Module: etherneco_tx_arbiter

Interface
REQ-001 The parameter list SHALL be, one per line:
- DATA_WIDTH, 8, byte-lane width of all streams
- IFG_CYCLES, 12, idle aclk cycles inserted after every frame, 0..255
- FIXED_PRIORITY, 0, 1 = s0 always wins contention; 0 = round-robin
REQ-002 The port list SHALL be, one per line:
- aresetn  in  1  asynchronous active-low reset
- aclk  in  1  sole clock, all logic on rising edge
- s0_tfirst/s0_tlast/s0_tvalid  in  1 each  requester 0 (ring forward path) frame markers and valid
- s0_tdata  in  DATA_WIDTH  requester 0 data
- s0_tready  out  1  requester 0 ready
- s1_tfirst/s1_tlast/s1_tvalid  in  1 each  requester 1 (local originate path)
- s1_tdata  in  DATA_WIDTH  requester 1 data
- s1_tready  out  1  requester 1 ready
- m_tfirst/m_tlast/m_tvalid  out  1 each  shared PHY TX stream
- m_tdata  out  DATA_WIDTH  shared PHY TX data
- m_tready  in  1  PHY TX ready
- busy  out  1  state is not IDLE
- grant  out  2  one-hot current owner, 0 when no owner
- drop_count  out  16  stray beats discarded, saturating

Function
REQ-003 The arbiter SHALL be a state machine with states IDLE, GRANT0, GRANT1, GAP.
REQ-004 In IDLE a requester SHALL request only when sx_tvalid=1 and sx_tfirst=1.
REQ-005 In IDLE with exactly one requesting port, state SHALL move to GRANTx on the next edge.
REQ-006 Under contention with FIXED_PRIORITY=1, GRANT0 SHALL be chosen.
REQ-007 Under contention with FIXED_PRIORITY=0, the port not held in last_grant SHALL be chosen. last_grant SHALL update on every entry to GRANTx.
REQ-008 In IDLE, GAP and the non-owned port of GRANTx, m_tvalid SHALL be 0, and the non-owned sx_tready SHALL be 0 unless REQ-009 applies.
REQ-009 In IDLE, a beat with sx_tvalid=1 and sx_tfirst=0 is stray:
- sx_tready SHALL be 1 in that cycle, so the beat is consumed and discarded.
- drop_count SHALL increment by 1, or by 2 if both ports are stray in the same cycle, saturating at 0xFFFF.
REQ-010 In GRANTx the mux SHALL be combinational with zero latency:
- m_tdata/m_tfirst/m_tlast/m_tvalid SHALL equal the sx_* inputs.
- sx_tready SHALL equal m_tready.
REQ-011 Latency from a qualifying request in IDLE to the first m_tvalid SHALL be 1 cycle.
REQ-012 A grant SHALL be held for the whole frame; the owner releases only on a handshake (sx_tvalid & m_tready) with sx_tlast=1.
REQ-013 On that last handshake:
- If IFG_CYCLES>0, state SHALL go to GAP and load gap_cnt=IFG_CYCLES-1.
- If IFG_CYCLES=0, state SHALL go directly to IDLE.
REQ-014 In GAP, gap_cnt SHALL decrement each cycle; state SHALL go to IDLE on the edge where gap_cnt=0. Exactly IFG_CYCLES cycles SHALL separate the last beat of one frame from the next frame's grant decision cycle.
REQ-015 Owner valid gaps mid-frame (sx_tvalid=0 while in GRANTx) SHALL NOT release the grant.
REQ-016 m_tready low SHALL stall the owner without changing state.
REQ-017 A one-beat frame (tfirst=tlast=1) SHALL be granted, forwarded and released like any other frame.
REQ-018 Requests arriving during GRANTx or GAP SHALL wait. The arbiter SHALL NOT inspect or consume them before IDLE.
REQ-019 busy SHALL be 1 in GRANT0, GRANT1 and GAP. grant SHALL be 2'b01 in GRANT0, 2'b10 in GRANT1, and 0 otherwise.

Reset
REQ-020 When aresetn=0, the block SHALL asynchronously enter this reset state:
- state=IDLE, gap_cnt=0, last_grant=1 (so s0 wins the first round-robin contention), drop_count=0.
- All tready outputs, m_tvalid, m_tfirst, m_tlast, busy and grant SHALL be 0.
- m_tdata SHALL be 0.
REQ-021 Reset asserted mid-frame SHALL abandon the frame with no completion beat. After release, a requester continuing that frame (tfirst=0) SHALL be treated as stray per REQ-009.
REQ-022 After reset release, the first grant decision SHALL occur on the second rising aclk edge.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Single requester: s1 sends a 64-byte frame with m_tready=1 -> m_* mirrors s1 one cycle after the request, grant=2'b10, and the next grant is no earlier than 12 cycles after tlast (IFG_CYCLES=12).
- Contention, round-robin: s0 and s1 both hold frames continuously, three frames each -> output order s0,s1,s0,s1,s0,s1, with no beats interleaved between frames.
- Contention, FIXED_PRIORITY=1: s0 always requesting -> s1 never granted and s1_tready stays 0.
- Backpressure: m_tready toggles at a 50% random rate and s0 inserts valid gaps mid-frame -> the received byte sequence equals the sent sequence, grant is held throughout, and the frame is released only on the tlast handshake.
- Stray beats: 5 beats with tfirst=0 on s1 while IDLE -> all five consumed, drop_count=5, m_tvalid stays 0. Pushing drop_count to 0xFFFF and adding one more stray beat -> drop_count holds at 0xFFFF.
- Reset mid-frame: aresetn=0 at beat 20 of a 60-byte frame -> outputs go to 0 immediately. The remaining 40 beats are dropped as strays (drop_count=40), and the next frame with tfirst=1 is granted normally.
